// File: rtl/branch_predict_resolve_pkg.sv
// Shared definitions for the branch resolution unit: branch-type codes,
// 2-bit counter states and the counter training rule.
package branch_predict_resolve_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LT   = 3'd3,
        BR_LTU  = 3'd4,
        BR_GE   = 3'd5,
        BR_GEU  = 3'd6,
        BR_RSVD = 3'd7
    } br_type_e;

    localparam logic [1:0] BHT_SNT = 2'd0;
    localparam logic [1:0] BHT_WNT = 2'd1;
    localparam logic [1:0] BHT_WT  = 2'd2;
    localparam logic [1:0] BHT_ST  = 2'd3;

    // Codes 0 and 7 are not branches and must never train or count.
    function automatic logic is_branch(input logic [2:0] br_type);
        return (br_type >= 3'd1) && (br_type <= 3'd6);
    endfunction

    function automatic logic [1:0] bht_train(input logic [1:0] cnt, input logic taken);
        if (taken)
            return (cnt == BHT_ST) ? BHT_ST : cnt + 2'd1;
        else
            return (cnt == BHT_SNT) ? BHT_SNT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predict_resolve_if.sv
// Fetch lookup, resolution request and result/statistics bundle.
interface branch_predict_resolve_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  pred_pc;
    logic             pred_taken;
    logic             res_valid;
    logic             res_flush;
    logic [2:0]       res_type;
    logic [XLEN-1:0]  res_pc;
    logic [XLEN-1:0]  res_op1;
    logic [XLEN-1:0]  res_op2;
    logic             res_pred_taken;
    logic             out_valid;
    logic             out_taken;
    logic             out_mispredict;
    logic [CNT_W-1:0] stat_branches;
    logic [CNT_W-1:0] stat_mispredicts;

    modport master (
        output pred_pc, res_valid, res_flush, res_type, res_pc,
               res_op1, res_op2, res_pred_taken,
        input  pred_taken, out_valid, out_taken, out_mispredict,
               stat_branches, stat_mispredicts
    );

    modport slave (
        input  pred_pc, res_valid, res_flush, res_type, res_pc,
               res_op1, res_op2, res_pred_taken,
        output pred_taken, out_valid, out_taken, out_mispredict,
               stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_predict_resolve_branch_cmp.sv
// Combinational branch condition evaluator; non-branch codes evaluate
// to not-taken.
module branch_cmp
    import branch_predict_resolve_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      br_type,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            taken
);
    logic eq;
    logic lt;
    logic ltu;

    assign eq  = (op1 == op2);
    assign lt  = ($signed(op1) < $signed(op2));
    assign ltu = (op1 < op2);

    always_comb begin
        taken = 1'b0;
        case (br_type)
            BR_EQ:   taken = eq;
            BR_NE:   taken = !eq;
            BR_LT:   taken = lt;
            BR_LTU:  taken = ltu;
            BR_GE:   taken = !lt;
            BR_GEU:  taken = !ltu;
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_predict_resolve.sv
// Branch resolution with a bimodal predictor: evaluates the condition,
// flags mispredictions one cycle later, trains the counters, keeps statistics.
module branch_predict_resolve
    import branch_predict_resolve_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int PC_LSB      = 2,
    parameter int CNT_W       = 32
) (
    input logic                    clk,
    input logic                    rst,
    branch_predict_resolve_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    // Flip-flop table: fetch reads it asynchronously, so it cannot be a RAM.
    logic [1:0] bht_reg  [BHT_ENTRIES];
    logic [1:0] bht_next [BHT_ENTRIES];

    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic             accept;
    logic             cond_taken;
    logic             mispredict;
    logic             unused_pc_bits;

    logic             out_valid_reg;
    logic             out_taken_reg;
    logic             out_mispredict_reg;
    logic [CNT_W-1:0] stat_branches_reg;
    logic [CNT_W-1:0] stat_mispredicts_reg;

    assign pred_idx       = bus.pred_pc[PC_LSB +: IDX_W];
    assign res_idx        = bus.res_pc[PC_LSB +: IDX_W];
    assign unused_pc_bits = ^{bus.pred_pc, bus.res_pc};

    assign accept     = bus.res_valid && !bus.res_flush && is_branch(bus.res_type);
    assign mispredict = cond_taken != bus.res_pred_taken;

    branch_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .br_type (bus.res_type),
        .op1     (bus.res_op1),
        .op2     (bus.res_op2),
        .taken   (cond_taken)
    );

    for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
        assign bht_next[gi] = (accept && (res_idx == IDX_W'(gi)))
                            ? bht_train(bht_reg[gi], cond_taken)
                            : bht_reg[gi];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_reg[i] <= rst ? BHT_WNT : bht_next[i];
        end
    end

    // Statistics hold at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg        <= 1'b0;
            out_taken_reg        <= 1'b0;
            out_mispredict_reg   <= 1'b0;
            stat_branches_reg    <= '0;
            stat_mispredicts_reg <= '0;
        end else begin
            out_valid_reg      <= accept;
            out_taken_reg      <= accept && cond_taken;
            out_mispredict_reg <= accept && mispredict;
            if (accept && (stat_branches_reg != '1))
                stat_branches_reg <= stat_branches_reg + 1'b1;
            if (accept && mispredict && (stat_mispredicts_reg != '1))
                stat_mispredicts_reg <= stat_mispredicts_reg + 1'b1;
        end
    end

    assign bus.pred_taken       = bht_reg[pred_idx][1];
    assign bus.out_valid        = out_valid_reg;
    assign bus.out_taken        = out_taken_reg;
    assign bus.out_mispredict   = out_mispredict_reg;
    assign bus.stat_branches    = stat_branches_reg;
    assign bus.stat_mispredicts = stat_mispredicts_reg;
endmodule
